// File: rtl/writeback_unit.sv
// Writeback unit: W-stage driver for the 32x32 register file write port.
//
// Captures the retiring instruction from M, extracts and extends load data
// from the one-cycle-latency data memory, drives the register file write
// port, provides a one-entry bypass for the register file's registered read
// port, and counts retired instructions.
//
// Ports:
//   clock, reset_n          clock and asynchronous active-low reset
//   in_*                    M-stage instruction fields
//   kill                    flush; drops the instruction entering W
//   mem_rdata               load word, valid in the W cycle of a load
//   rs1_addr, rs2_addr      read addresses presented to the register file
//   rf_addr_rd, rf_data_rd, rf_write_enable   register file write port
//   fwd_rsN_hit/fwd_rsN_data                  bypass for stale read data
//   instret                 retired-instruction count
module writeback_unit #(
    parameter int unsigned INSTRET_WIDTH = 64,
    parameter bit          ENABLE_BYPASS = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic                     in_reg_write,
    input  logic [4:0]               in_rd,
    input  logic [1:0]               in_wb_sel,
    input  logic [31:0]              in_alu_result,
    input  logic [31:0]              in_pc,
    input  logic [2:0]               in_funct3,
    input  logic                     kill,
    input  logic [31:0]              mem_rdata,
    input  logic [4:0]               rs1_addr,
    input  logic [4:0]               rs2_addr,
    output logic [4:0]               rf_addr_rd,
    output logic [31:0]              rf_data_rd,
    output logic                     rf_write_enable,
    output logic                     fwd_rs1_hit,
    output logic [31:0]              fwd_rs1_data,
    output logic                     fwd_rs2_hit,
    output logic [31:0]              fwd_rs2_data,
    output logic [INSTRET_WIDTH-1:0] instret
);

    localparam logic [1:0] WbAlu  = 2'b00;
    localparam logic [1:0] WbLoad = 2'b01;
    localparam logic [1:0] WbPc4  = 2'b10;
    localparam logic [1:0] WbNone = 2'b11;

    // W-stage registers
    logic                     w_valid_q;
    logic                     w_reg_write_q;
    logic [4:0]               w_rd_q;
    logic [1:0]               w_wb_sel_q;
    logic [31:0]              w_alu_q;
    logic [31:0]              w_pc_q;
    logic [2:0]               w_funct3_q;
    logic [INSTRET_WIDTH-1:0] instret_q;

    // Bypass registers, aligned with the register file's registered read data
    logic        last_we_q;
    logic [4:0]  last_rd_q;
    logic [31:0] last_data_q;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        kill_q;

    logic [31:0] load_data;
    logic        load_legal;
    logic        legal_load;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            w_valid_q     <= 1'b0;
            w_reg_write_q <= 1'b0;
            w_rd_q        <= 5'd0;
            w_wb_sel_q    <= 2'b00;
            w_alu_q       <= 32'd0;
            w_pc_q        <= 32'd0;
            w_funct3_q    <= 3'd0;
            instret_q     <= '0;
            last_we_q     <= 1'b0;
            last_rd_q     <= 5'd0;
            last_data_q   <= 32'd0;
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            kill_q        <= 1'b0;
        end else begin
            w_valid_q     <= in_valid & ~kill;
            w_reg_write_q <= in_reg_write;
            w_rd_q        <= in_rd;
            w_wb_sel_q    <= in_wb_sel;
            w_alu_q       <= in_alu_result;
            w_pc_q        <= in_pc;
            w_funct3_q    <= in_funct3;
            if (w_valid_q) begin
                instret_q <= instret_q + 1'b1;
            end
            last_we_q     <= rf_write_enable;
            last_rd_q     <= rf_addr_rd;
            last_data_q   <= rf_data_rd;
            rs1_q         <= rs1_addr;
            rs2_q         <= rs2_addr;
            kill_q        <= kill;
        end
    end

    // Load extraction from the word returned by memory
    always_comb begin
        load_byte = mem_rdata[7:0];
        case (w_alu_q[1:0])
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = mem_rdata[7:0];
        endcase
        load_half  = w_alu_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data  = mem_rdata;
        load_legal = 1'b1;
        case (w_funct3_q)
            3'b000: load_data = {{24{load_byte[7]}}, load_byte};
            3'b100: load_data = {24'd0, load_byte};
            3'b001: load_data = {{16{load_half[15]}}, load_half};
            3'b101: load_data = {16'd0, load_half};
            3'b010: load_data = mem_rdata;
            default: load_legal = 1'b0;
        endcase
    end

    // Only loads can be illegal; other writeback sources ignore funct3
    assign legal_load = (w_wb_sel_q != WbLoad) | load_legal;

    always_comb begin
        rf_data_rd = w_alu_q;
        case (w_wb_sel_q)
            WbAlu:   rf_data_rd = w_alu_q;
            WbLoad:  rf_data_rd = load_data;
            WbPc4:   rf_data_rd = w_pc_q + 32'd4;
            default: rf_data_rd = w_alu_q;
        endcase
    end

    assign rf_addr_rd      = w_rd_q;
    assign rf_write_enable = w_valid_q & w_reg_write_q & (w_wb_sel_q != WbNone)
                           & (w_rd_q != 5'd0) & legal_load;

    // last_we already implies last_rd != 0, so x0 never hits
    assign fwd_rs1_hit  = ENABLE_BYPASS & last_we_q & ~kill_q & (rs1_q == last_rd_q);
    assign fwd_rs2_hit  = ENABLE_BYPASS & last_we_q & ~kill_q & (rs2_q == last_rd_q);
    assign fwd_rs1_data = last_data_q;
    assign fwd_rs2_data = last_data_q;

    assign instret = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_reg_write;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        kill;
    logic [31:0] mem_rdata;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rf_addr_rd;
    logic [31:0] rf_data_rd;
    logic        rf_write_enable;
    logic        fwd_rs1_hit;
    logic [31:0] fwd_rs1_data;
    logic        fwd_rs2_hit;
    logic [31:0] fwd_rs2_data;
    logic [63:0] instret;

    int total = 0;
    int bad = 0;
    logic [63:0] exp_instret = 64'd0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];

    writeback_unit #(
        .INSTRET_WIDTH(64),
        .ENABLE_BYPASS(1'b1)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_reg_write   (in_reg_write),
        .in_rd          (in_rd),
        .in_wb_sel      (in_wb_sel),
        .in_alu_result  (in_alu_result),
        .in_pc          (in_pc),
        .in_funct3      (in_funct3),
        .kill           (kill),
        .mem_rdata      (mem_rdata),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rf_addr_rd     (rf_addr_rd),
        .rf_data_rd     (rf_data_rd),
        .rf_write_enable(rf_write_enable),
        .fwd_rs1_hit    (fwd_rs1_hit),
        .fwd_rs1_data   (fwd_rs1_data),
        .fwd_rs2_hit    (fwd_rs2_hit),
        .fwd_rs2_data   (fwd_rs2_data),
        .instret        (instret)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one instruction in cycle T and queue the write expected in T+1.
    // Returns 1ns after the posedge that starts T+1.
    task automatic present(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] pc, input logic [2:0] f3, input logic k,
                           input logic ewe, input logic [31:0] edata);
        exp_t e;
        @(negedge clock);
        in_valid      = v;
        in_reg_write  = rw;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc         = pc;
        in_funct3     = f3;
        kill          = k;
        e.we = ewe; e.rd = rd; e.data = edata;
        sb.push_back(e);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
    endtask

    task automatic idle(input logic k);
        @(negedge clock);
        in_valid = 1'b0;
        kill     = k;
        @(posedge clock);
        #1;
        kill = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== 38'd0) begin
            bad++;
            $display("FAIL reset_wport: got we=%0b rd=%0d data=%h want 0", rf_write_enable,
                     rf_addr_rd, rf_data_rd);
        end
        total++;
        if ({fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data, instret} !== 130'd0) begin
            bad++;
            $display("FAIL reset_fwd: got h1=%0b h2=%0b d1=%h d2=%h instret=%0d want 0",
                     fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data, instret);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_alu;
        exp_t e;
        present(1, 1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h100, 3'd0, 0, 1, 32'hDEADBEEF);
        e = sb.pop_front();
        total++;
        if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {e.we, e.rd, e.data}) begin
            bad++;
            $display("FAIL alu_write: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                     rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.rd, e.data);
        end
        idle(0);
        exp_instret = exp_instret + 1;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL alu_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3_t[6]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
        logic [1:0]  off_t[6] = '{2'd0, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0};
        logic        we_t[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] dat_t[6] = '{32'hFFFFFF81, 32'h00000080, 32'hFFFF80F1, 32'h00007F81,
                                  32'h80F17F81, 32'h0};
        exp_t e;
        mem_rdata = 32'h80F17F81;
        for (int i = 0; i < 6; i++) begin
            present(1, 1, 5'd10, 2'b01, {30'h400, off_t[i]}, 32'h200, f3_t[i], 0,
                    we_t[i], dat_t[i]);
            e = sb.pop_front();
            total++;
            if (rf_write_enable !== e.we || rf_addr_rd !== e.rd ||
                (e.we && rf_data_rd !== e.data)) begin
                bad++;
                $display("FAIL load_f3_%0d: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                         f3_t[i], rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.rd, e.data);
            end
        end
        idle(0);
        exp_instret = exp_instret + 6;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL load_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_jal;
        exp_t e;
        present(1, 1, 5'd1, 2'b10, 32'h0, 32'hFFFFFFFC, 3'd0, 0, 1, 32'h00000000);
        e = sb.pop_front();
        total++;
        if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {e.we, e.rd, e.data}) begin
            bad++;
            $display("FAIL jal_wrap: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                     rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.rd, e.data);
        end
        present(1, 1, 5'd0, 2'b10, 32'h0, 32'h00001000, 3'd0, 0, 0, 32'h00001004);
        e = sb.pop_front();
        total++;
        if (rf_write_enable !== e.we) begin
            bad++;
            $display("FAIL jal_x0: got we=%0b want %0b", rf_write_enable, e.we);
        end
        present(1, 1, 5'd3, 2'b11, 32'h55, 32'h0, 3'd0, 0, 0, 32'h55);
        e = sb.pop_front();
        total++;
        if (rf_write_enable !== e.we) begin
            bad++;
            $display("FAIL wbsel_none: got we=%0b want %0b", rf_write_enable, e.we);
        end
        idle(0);
        exp_instret = exp_instret + 3;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL jal_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_bypass;
        exp_t e;
        // Both ports reading x7 while it is being written
        present(1, 1, 5'd7, 2'b00, 32'h1234, 32'h0, 3'd0, 0, 1, 32'h1234);
        e = sb.pop_front();
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        idle(0);
        total++;
        if ({fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data} !=={2'b11, e.data, e.data})
        begin
            bad++;
            $display("FAIL bypass_both: got h1=%0b h2=%0b d1=%h d2=%h want 1 1 %h", fwd_rs1_hit,
                     fwd_rs2_hit, fwd_rs1_data, fwd_rs2_data, e.data);
        end
        // Back-to-back writes to x7; only rs1 matches
        present(1, 1, 5'd7, 2'b00, 32'hAAAA0001, 32'h0, 3'd0, 0, 1, 32'hAAAA0001);
        e = sb.pop_front();
        present(1, 1, 5'd7, 2'b00, 32'hBBBB0002, 32'h0, 3'd0, 0, 1, 32'hBBBB0002);
        e = sb.pop_front();
        rs1_addr = 5'd7;
        rs2_addr = 5'd3;
        idle(0);
        total++;
        if ({fwd_rs1_hit, fwd_rs2_hit, fwd_rs1_data} !== {2'b10, e.data}) begin
            bad++;
            $display("FAIL bypass_b2b: got h1=%0b h2=%0b d1=%h want 1 0 %h", fwd_rs1_hit,
                     fwd_rs2_hit, fwd_rs1_data, e.data);
        end
        // Kill in the write cycle suppresses the bypass, not the write
        present(1, 1, 5'd7, 2'b00, 32'h5678, 32'h0, 3'd0, 0, 1, 32'h5678);
        e = sb.pop_front();
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        @(negedge clock);
        kill = 1'b1;
        #1;
        total++;
        if ({rf_write_enable, rf_addr_rd, rf_data_rd} !== {e.we, e.rd, e.data}) begin
            bad++;
            $display("FAIL kill_w_writes: got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h",
                     rf_write_enable, rf_addr_rd, rf_data_rd, e.we, e.rd, e.data);
        end
        @(posedge clock);
        #1;
        kill = 1'b0;
        total++;
        if ({fwd_rs1_hit, fwd_rs2_hit} !== 2'b00) begin
            bad++;
            $display("FAIL bypass_kill: got h1=%0b h2=%0b want 0 0", fwd_rs1_hit, fwd_rs2_hit);
        end
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        exp_instret = exp_instret + 4;
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL bypass_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_kill;
        exp_t e;
        present(1, 1, 5'd12, 2'b00, 32'hCAFE, 32'h0, 3'd0, 1, 0, 32'hCAFE);
        e = sb.pop_front();
        total++;
        if (rf_write_enable !== e.we) begin
            bad++;
            $display("FAIL kill_drop: got we=%0b want %0b", rf_write_enable, e.we);
        end
        idle(0);
        total++;
        if (instret !== exp_instret) begin
            bad++;
            $display("FAIL kill_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        present(1, 1, 5'd9, 2'b00, 32'h9999, 32'h0, 3'd0, 0, 1, 32'h9999);
        e = sb.pop_front();
        total++;
        if (rf_write_enable !== e.we) begin
            bad++;
            $display("FAIL pre_reset_we: got we=%0b want %0b", rf_write_enable, e.we);
        end
        #1;
        reset_n = 1'b0;
        #1;
        exp_instret = 64'd0;
        total++;
        if (rf_write_enable !== 1'b0 || instret !== exp_instret) begin
            bad++;
            $display("FAIL async_reset: got we=%0b instret=%0d want 0 0", rf_write_enable,
                     instret);
        end
        @(negedge clock);
        reset_n = 1'b1;
        idle(0);
        total++;
        if (rf_write_enable !== 1'b0 || instret !== exp_instret) begin
            bad++;
            $display("FAIL post_reset: got we=%0b instret=%0d want 0 0", rf_write_enable,
                     instret);
        end
    endtask

    initial begin
        in_valid      = 1'b0;
        in_reg_write  = 1'b0;
        in_rd         = 5'd0;
        in_wb_sel     = 2'b00;
        in_alu_result = 32'd0;
        in_pc         = 32'd0;
        in_funct3     = 3'd0;
        kill          = 1'b0;
        mem_rdata     = 32'd0;
        rs1_addr      = 5'd0;
        rs2_addr      = 5'd0;
        reset_n       = 1'b0;

        test_reset();
        test_alu();
        test_loads();
        test_jal();
        test_bypass();
        test_kill();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
